// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the peripheral SPI bus arbiter and its shift engine.
package spi_arb_pkg;

    localparam int         FRAME_BITS_DEF = 16;
    localparam logic [7:0] CS_NONE        = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_MCU       = 3'd1,
        ST_INT_SETUP = 3'd2,
        ST_INT_SHIFT = 3'd3,
        ST_INT_HOLD  = 3'd4
    } arb_state_e;

    typedef enum logic [1:0] {
        PH_IDLE  = 2'd0,
        PH_SETUP = 2'd1,
        PH_SHIFT = 2'd2,
        PH_HOLD  = 2'd3
    } eng_phase_e;

endpackage

// File: rtl/spi_bus_arbiter_shift_engine.sv
// Internal mode-0 SPI master: chip-select setup, FRAME_BITS MSB-first shift, chip-select hold.
module spi_shift_engine
    import spi_arb_pkg::*;
#(
    parameter int DIV        = 4,
    parameter int FRAME_BITS = FRAME_BITS_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [FRAME_BITS-1:0] wdata,
    input  logic                  miso,
    output logic                  sclk,
    output logic                  mosi,
    output logic                  busy,
    output logic                  setup_end,
    output logic                  shift_end,
    output logic                  hold_end,
    output logic                  done,
    output logic [FRAME_BITS-1:0] rdata
);

    localparam int HALVES = 2 * FRAME_BITS;
    localparam int HW     = $clog2(HALVES);

    eng_phase_e            phase_q, phase_d;
    logic [7:0]            div_cnt_q, div_cnt_d;
    logic [HW-1:0]         half_cnt_q, half_cnt_d;
    logic                  sclk_q, sclk_d;
    logic                  done_q, done_d;
    logic [FRAME_BITS-1:0] tx_q, tx_d;
    logic [FRAME_BITS-1:0] rx_q, rx_d;
    logic [FRAME_BITS-1:0] rdata_q, rdata_d;
    logic                  div_end;
    logic                  last_half;

    assign div_end   = (div_cnt_q == 8'(DIV - 1));
    assign last_half = (half_cnt_q == HW'(HALVES - 1));

    always_comb begin
        phase_d    = phase_q;
        div_cnt_d  = div_cnt_q;
        half_cnt_d = half_cnt_q;
        sclk_d     = sclk_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        rdata_d    = rdata_q;
        done_d     = 1'b0;
        case (phase_q)
            PH_IDLE: begin
                if (start) begin
                    phase_d   = PH_SETUP;
                    div_cnt_d = 8'd0;
                    sclk_d    = 1'b0;
                    tx_d      = wdata;
                end
            end
            PH_SETUP: begin
                if (div_end) begin
                    phase_d    = PH_SHIFT;
                    div_cnt_d  = 8'd0;
                    half_cnt_d = '0;
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end
            PH_SHIFT: begin
                if (div_end) begin
                    div_cnt_d  = 8'd0;
                    sclk_d     = ~sclk_q;
                    half_cnt_d = half_cnt_q + 1'b1;
                    // Low half ends with the sampling edge, high half with the shifting edge.
                    if (!sclk_q) begin
                        rx_d = {rx_q[FRAME_BITS-2:0], miso};
                    end else begin
                        tx_d = {tx_q[FRAME_BITS-2:0], 1'b0};
                    end
                    if (last_half) begin
                        phase_d = PH_HOLD;
                        sclk_d  = 1'b0;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end
            PH_HOLD: begin
                if (div_end) begin
                    phase_d   = PH_IDLE;
                    div_cnt_d = 8'd0;
                    done_d    = 1'b1;
                    rdata_d   = rx_q;
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end
            default: phase_d = PH_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q    <= PH_IDLE;
            div_cnt_q  <= 8'd0;
            half_cnt_q <= '0;
            sclk_q     <= 1'b0;
            done_q     <= 1'b0;
            tx_q       <= '0;
            rx_q       <= '0;
            rdata_q    <= '0;
        end else begin
            phase_q    <= phase_d;
            div_cnt_q  <= div_cnt_d;
            half_cnt_q <= half_cnt_d;
            sclk_q     <= sclk_d;
            done_q     <= done_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            rdata_q    <= rdata_d;
        end
    end

    assign sclk      = sclk_q;
    assign mosi      = tx_q[FRAME_BITS-1];
    assign busy      = (phase_q != PH_IDLE);
    assign setup_end = (phase_q == PH_SETUP) && div_end;
    assign shift_end = (phase_q == PH_SHIFT) && div_end && last_half;
    assign hold_end  = (phase_q == PH_HOLD) && div_end;
    assign done      = done_q;
    assign rdata     = rdata_q;

endmodule

// File: rtl/spi_bus_arbiter.sv
// Shares the peripheral SPI bus between MCU pass-through and the internal master.
// Optional MCU ownership watchdog is built when SPI_ARB_WDOG_EN is defined.
module spi_bus_arbiter
    import spi_arb_pkg::*;
#(
    parameter int DIV         = 4,
    parameter int FRAME_BITS  = FRAME_BITS_DEF,
    parameter int WDOG_CYCLES = 1_000_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mcu_cs_n,
    input  logic                  mcu_special_n,
    input  logic                  mcu_sclk,
    input  logic                  mcu_mosi,
    output logic                  mcu_miso,
    input  logic [7:0]            reg_mux,
    input  logic                  int_req,
    input  logic [2:0]            int_sel,
    input  logic [FRAME_BITS-1:0] int_wdata,
    output logic                  int_gnt,
    output logic                  int_done,
    output logic [FRAME_BITS-1:0] int_rdata,
    output logic [7:0]            per_cs_n,
    output logic                  per_sclk,
    output logic                  per_mosi,
    input  logic [7:0]            per_miso,
    output logic                  err_collide,
    input  logic                  clr_err
);

    arb_state_e state_q, state_d;
    logic [1:0] cs_sync_q, spec_sync_q;
    logic       cs_prev_q;
    logic [2:0] sel_q, sel_d;
    logic       gnt_q, gnt_d;
    logic       err_q, err_d;
    logic       block_q, block_d;
    logic       cs_s, spec_s, cs_fall, in_int, collide, mcu_req, take_int;
    logic       wdog_trip, wdog_set;
    logic       eng_sclk, eng_mosi, eng_busy, eng_setup_end, eng_shift_end, eng_hold_end;

    assign cs_s    = cs_sync_q[1];
    assign spec_s  = spec_sync_q[1];
    assign cs_fall = cs_prev_q & ~cs_s;
    assign in_int  = (state_q == ST_INT_SETUP) || (state_q == ST_INT_SHIFT) ||
                     (state_q == ST_INT_HOLD);
    // Register-bank accesses (special_n low) never contend for the bus, so they never collide.
    assign collide  = in_int && cs_fall && spec_s;
    assign mcu_req  = !cs_s && spec_s && (reg_mux != 8'h00) && !block_q;
    assign take_int = (state_q == ST_IDLE) && !mcu_req && int_req && !eng_busy;

`ifdef SPI_ARB_WDOG_EN
    localparam int WW = $clog2(WDOG_CYCLES + 1);
    logic [WW-1:0] wdog_cnt_q, wdog_cnt_d;
    logic          wdog_trip_q, wdog_trip_d;

    always_comb begin
        wdog_cnt_d  = wdog_cnt_q;
        wdog_trip_d = wdog_trip_q;
        if (state_q != ST_MCU) begin
            wdog_cnt_d  = '0;
            wdog_trip_d = 1'b0;
        end else if (!wdog_trip_q) begin
            wdog_cnt_d = wdog_cnt_q + 1'b1;
            if (wdog_cnt_d == WW'(WDOG_CYCLES)) wdog_trip_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_cnt_q  <= '0;
            wdog_trip_q <= 1'b0;
        end else begin
            wdog_cnt_q  <= wdog_cnt_d;
            wdog_trip_q <= wdog_trip_d;
        end
    end

    assign wdog_trip = wdog_trip_q;
    assign wdog_set  = wdog_trip_d & ~wdog_trip_q;
`else
    logic wdog_unused;
    assign wdog_unused = (WDOG_CYCLES == 0);
    assign wdog_trip   = 1'b0;
    assign wdog_set    = 1'b0;
`endif

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (mcu_req)       state_d = ST_MCU;
                else if (take_int) state_d = ST_INT_SETUP;
            end
            ST_MCU:       if (cs_s)          state_d = ST_IDLE;
            ST_INT_SETUP: if (eng_setup_end) state_d = ST_INT_SHIFT;
            ST_INT_SHIFT: if (eng_shift_end) state_d = ST_INT_HOLD;
            ST_INT_HOLD:  if (eng_hold_end)  state_d = ST_IDLE;
            default:                         state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        sel_d   = take_int ? int_sel : sel_q;
        gnt_d   = take_int;
        block_d = block_q;
        if (cs_s)    block_d = 1'b0;
        if (collide) block_d = 1'b1;
        err_d = err_q;
        if (collide || wdog_set) err_d = 1'b1;
        else if (clr_err)        err_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cs_sync_q   <= 2'b11;
            spec_sync_q <= 2'b11;
            cs_prev_q   <= 1'b1;
            sel_q       <= 3'd0;
            gnt_q       <= 1'b0;
            err_q       <= 1'b0;
            block_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cs_sync_q   <= {cs_sync_q[0], mcu_cs_n};
            spec_sync_q <= {spec_sync_q[0], mcu_special_n};
            cs_prev_q   <= cs_s;
            sel_q       <= sel_d;
            gnt_q       <= gnt_d;
            err_q       <= err_d;
            block_q     <= block_d;
        end
    end

    // Output muxing; MCU paths stay combinational from the raw pins.
    always_comb begin
        per_cs_n = CS_NONE;
        per_sclk = 1'b0;
        per_mosi = 1'b0;
        case (state_q)
            ST_MCU: begin
                per_cs_n = (mcu_cs_n || wdog_trip) ? CS_NONE : ~reg_mux;
                per_sclk = mcu_sclk;
                per_mosi = mcu_mosi;
            end
            ST_INT_SETUP, ST_INT_SHIFT: begin
                per_cs_n = ~(8'b1 << sel_q);
                per_sclk = eng_sclk;
                per_mosi = eng_mosi;
            end
            ST_INT_HOLD: begin
                per_sclk = eng_sclk;
                per_mosi = eng_mosi;
            end
            default: ;
        endcase
    end

    assign mcu_miso    = (state_q == ST_MCU) && |(reg_mux & per_miso);
    assign int_gnt     = gnt_q;
    assign err_collide = err_q;

    spi_shift_engine #(
        .DIV        (DIV),
        .FRAME_BITS (FRAME_BITS)
    ) u_engine (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (take_int),
        .wdata     (int_wdata),
        .miso      (per_miso[sel_q]),
        .sclk      (eng_sclk),
        .mosi      (eng_mosi),
        .busy      (eng_busy),
        .setup_end (eng_setup_end),
        .shift_end (eng_shift_end),
        .hold_end  (eng_hold_end),
        .done      (int_done),
        .rdata     (int_rdata)
    );

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed self-checking bench for spi_bus_arbiter with default parameters.
module tb_spi_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mcu_cs_n, mcu_special_n, mcu_sclk, mcu_mosi;
    logic        mcu_miso;
    logic [7:0]  reg_mux;
    logic        int_req;
    logic [2:0]  int_sel;
    logic [15:0] int_wdata;
    logic        int_gnt, int_done;
    logic [15:0] int_rdata;
    logic [7:0]  per_cs_n;
    logic        per_sclk, per_mosi;
    logic [7:0]  per_miso;
    logic        err_collide, clr_err;
    logic [7:0]  loop_mask;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int sclk_rise = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge per_sclk) sclk_rise <= sclk_rise + 1;

    assign per_miso = loop_mask & {8{per_mosi}};

    spi_bus_arbiter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mcu_cs_n      (mcu_cs_n),
        .mcu_special_n (mcu_special_n),
        .mcu_sclk      (mcu_sclk),
        .mcu_mosi      (mcu_mosi),
        .mcu_miso      (mcu_miso),
        .reg_mux       (reg_mux),
        .int_req       (int_req),
        .int_sel       (int_sel),
        .int_wdata     (int_wdata),
        .int_gnt       (int_gnt),
        .int_done      (int_done),
        .int_rdata     (int_rdata),
        .per_cs_n      (per_cs_n),
        .per_sclk      (per_sclk),
        .per_mosi      (per_mosi),
        .per_miso      (per_miso),
        .err_collide   (err_collide),
        .clr_err       (clr_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic start_int(input logic [2:0] sel, input logic [15:0] wd);
        @(negedge clk);
        int_sel   = sel;
        int_wdata = wd;
        int_req   = 1'b1;
    endtask

    task automatic wait_gnt(input string tag, input int budget, output int gc);
        gc = -1;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (int_gnt) begin
                gc = cyc;
                break;
            end
        end
        check({tag, "_gnt_seen"}, 32'(gc >= 0), 32'd1);
        @(negedge clk);
        int_req = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int gc, input logic [15:0] exp_rd);
        int dc;
        dc = -1;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (int_done) begin
                dc = cyc;
                break;
            end
        end
        check({tag, "_latency"}, 32'(dc - gc), 32'd136);
        check({tag, "_rdata"}, {16'h0, int_rdata}, {16'h0, exp_rd});
        check({tag, "_gnt_at_done"}, {31'h0, int_gnt}, 32'd0);
    endtask

    initial begin
        int gc, s0, dly, bad, ndone;
        rst_n = 1'b0; mcu_cs_n = 1'b1; mcu_special_n = 1'b1; mcu_sclk = 1'b0;
        mcu_mosi = 1'b0; reg_mux = 8'h00; int_req = 1'b0; int_sel = 3'd0;
        int_wdata = 16'h0; clr_err = 1'b0; loop_mask = 8'h00;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_cs_n",   {24'h0, per_cs_n}, 32'hFF);
        check("rst_sclk",   {31'h0, per_sclk}, 32'd0);
        check("rst_mosi",   {31'h0, per_mosi}, 32'd0);
        check("rst_miso",   {31'h0, mcu_miso}, 32'd0);
        check("rst_gnt",    {31'h0, int_gnt}, 32'd0);
        check("rst_done",   {31'h0, int_done}, 32'd0);
        check("rst_rdata",  {16'h0, int_rdata}, 32'd0);
        check("rst_err",    {31'h0, err_collide}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Internal frame, loopback on per_miso[1]
        loop_mask = 8'h02;
        start_int(3'd1, 16'hA5C3);
        wait_gnt("int1", 20, gc);
        s0 = sclk_rise;
        check("int1_cs_n", {24'h0, per_cs_n}, 32'hFD);
        repeat (70) @(posedge clk);
        #1;
        check("int1_cs_mid", {24'h0, per_cs_n}, 32'hFD);
        wait_done("int1", gc, 16'hA5C3);
        check("int1_sclk_pulses", 32'(sclk_rise - s0), 32'd16);
        check("int1_cs_after", {24'h0, per_cs_n}, 32'hFF);
        @(posedge clk); #1;
        check("int1_done_1cyc", {31'h0, int_done}, 32'd0);

        // MCU access with reg_mux = 04
        @(negedge clk);
        reg_mux = 8'h04; loop_mask = 8'h04; mcu_cs_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("mcu_cs_n_lat3", {24'h0, per_cs_n}, 32'hFB);
        mcu_mosi = 1'b1; mcu_sclk = 1'b1; #1;
        check("mcu_miso_hi", {31'h0, mcu_miso}, 32'd1);
        check("mcu_sclk_pass", {31'h0, per_sclk}, 32'd1);
        mcu_mosi = 1'b0; #1;
        check("mcu_miso_lo", {31'h0, mcu_miso}, 32'd0);
        @(negedge clk);
        mcu_cs_n = 1'b1; #1;
        check("mcu_cs_release", {24'h0, per_cs_n}, 32'hFF);
        repeat (4) @(posedge clk);
        #1;
        check("mcu_back_idle_sclk", {31'h0, per_sclk}, 32'd0);
        @(negedge clk);
        mcu_sclk = 1'b0;

        // MCU request and int_req present together: MCU wins
        @(negedge clk);
        mcu_cs_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        loop_mask = 8'h08; int_sel = 3'd3; int_wdata = 16'h1234; int_req = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (int_gnt) bad++;
        end
        check("both_mcu_cs", {24'h0, per_cs_n}, 32'hFB);
        check("both_no_gnt_in_mcu", 32'(bad), 32'd0);
        @(negedge clk);
        mcu_cs_n = 1'b1;
        dly = cyc;
        wait_gnt("both", 20, gc);
        check("both_gnt_after_rise", 32'((gc - dly) >= 3), 32'd1);
        wait_done("both", gc, 16'h1234);

        // MCU cs_n falls mid internal frame
        loop_mask = 8'h02;
        start_int(3'd1, 16'h5A0F);
        wait_gnt("coll", 20, gc);
        repeat (40) @(posedge clk);
        @(negedge clk);
        reg_mux = 8'h04; mcu_cs_n = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("coll_err_set", {31'h0, err_collide}, 32'd1);
        check("coll_cs_kept", {24'h0, per_cs_n}, 32'hFD);
        wait_done("coll", gc, 16'h5A0F);
        check("coll_err_sticky", {31'h0, err_collide}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("coll_mcu_ignored", {24'h0, per_cs_n}, 32'hFF);
        @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check("coll_err_clr", {31'h0, err_collide}, 32'd0);
        mcu_cs_n = 1'b1;
        repeat (4) @(negedge clk);

        // special_n low: register-bank traffic never touches peripherals
        mcu_special_n = 1'b0;
        repeat (3) @(negedge clk);
        bad = 0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if ((i % 3) == 0) mcu_cs_n = ~mcu_cs_n;
            @(posedge clk); #1;
            if (per_cs_n !== 8'hFF) bad++;
        end
        check("special_cs_stays_ff", 32'(bad), 32'd0);
        @(negedge clk);
        mcu_cs_n = 1'b1;
        repeat (3) @(negedge clk);
        mcu_special_n = 1'b1;
        repeat (3) @(negedge clk);

        // Reset pulsed at bit 7 of an internal frame
        start_int(3'd1, 16'hA5C3);
        wait_gnt("rstmid", 20, gc);
        repeat (62) @(posedge clk);
        #1;
        check("rstmid_cs_before", {24'h0, per_cs_n}, 32'hFD);
        @(negedge clk);
        rst_n = 1'b0; #1;
        check("rstmid_cs_n", {24'h0, per_cs_n}, 32'hFF);
        check("rstmid_sclk", {31'h0, per_sclk}, 32'd0);
        check("rstmid_rdata", {16'h0, int_rdata}, 32'd0);
        ndone = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (int_done) ndone++;
            if (i == 2) begin
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        check("rstmid_no_done", 32'(ndone), 32'd0);
        start_int(3'd1, 16'h3C96);
        wait_gnt("after_rst", 20, gc);
        wait_done("after_rst", gc, 16'h3C96);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_bus_arbiter.md
# spi_bus_arbiter

Shares the downstream peripheral SPI bus (ADC03, DAC, flash and up to eight chip-selects) between the MCU pass-through path and an internal 16-bit SPI master used by on-FPGA sequencers such as ADC polling. Sits between the top-level MCU SPI pins plus the mux register and the peripheral pins. Owns the bus in exactly one mode at a time, never preempts a transfer in progress, and flags any MCU access that arrives while the internal master owns the bus.

## Interface
- DIV, 4: clk cycles per SCLK half-period for the internal master; legal range 2..255.
- FRAME_BITS, 16: internal frame length in bits.
- WDOG_CYCLES, 1_000_000: MCU ownership limit in clk cycles (only with the watchdog macro).
- clk  in  1  system clock (XTALCLK domain).
- rst_n  in  1  asynchronous active-low reset.
- mcu_cs_n  in  1  raw MCU chip-select, asynchronous to clk.
- mcu_special_n  in  1  low = MCU is addressing the register bank, not peripherals.
- mcu_sclk, mcu_mosi  in  1  raw MCU SPI clock and data.
- mcu_miso  out  1  MCU read data.
- reg_mux  in  8  one-hot peripheral select from the register bank.
- int_req  in  1  internal transfer request; held until int_gnt.
- int_sel  in  3  internal target peripheral index.
- int_wdata  in  FRAME_BITS  internal write frame.
- int_gnt  out  1  one-cycle pulse: request accepted, inputs latched.
- int_done  out  1  one-cycle pulse: int_rdata valid.
- int_rdata  out  FRAME_BITS  internal read frame.
- per_cs_n  out  8  peripheral chip-selects, active low.
- per_sclk, per_mosi  out  1  peripheral bus clock and data.
- per_miso  in  8  peripheral MISO vector.
- err_collide  out  1  sticky error flag.
- clr_err  in  1  clears err_collide.

## Operation
- mcu_cs_n and mcu_special_n pass through 2-FF synchronizers. mcu_req = synced cs_n low AND synced special_n high AND reg_mux != 0.
- States: IDLE, MCU, INT_SETUP, INT_SHIFT, INT_HOLD. Unreachable encodings return to IDLE.
- IDLE: mcu_req goes to MCU. Otherwise int_req pulses int_gnt, latches int_sel and int_wdata, and goes to INT_SETUP. When both are present, MCU wins.
- MCU: per_cs_n = mcu_cs_n ? 8'hFF : ~reg_mux, per_sclk = mcu_sclk, per_mosi = mcu_mosi, mcu_miso = |(reg_mux & per_miso). All four paths are combinational from the raw pins. Returns to IDLE when synced cs_n goes high.
- INT_SETUP: assert per_cs_n[sel] low, per_sclk low, per_mosi = frame MSB. Lasts DIV cycles.
- INT_SHIFT: SPI mode 0, MSB first. The rising edge samples per_miso[sel]; the falling edge shifts out the next bit. Runs FRAME_BITS full SCLK periods, ending with SCLK low.
- INT_HOLD: deassert per_cs_n and hold it high for DIV cycles. On exit, pulse int_done with int_rdata valid, then go to IDLE.
- In every non-MCU state, mcu_miso = 0 and per_sclk/per_mosi come from the internal master (0 in IDLE).
- Collision: synced cs_n falling while in any INT_* state sets err_collide. That MCU access is ignored until its cs_n rises. clr_err clears the flag; a simultaneous set wins.
- mcu_special_n low with cs_n low never grants the bus, so register-bank writes do not disturb peripherals.

## Timing
- Reset values: per_cs_n = 8'hFF, per_sclk = 0, per_mosi = 0, mcu_miso = 0, int_gnt = 0, int_done = 0, int_rdata = 0, err_collide = 0, state = IDLE.
- Reset asserted mid-transfer: outputs take their reset values immediately. No int_done is produced.
- MCU grant latency is 3 clk cycles after the cs_n fall. The MCU must allow at least 4 clk cycles between cs_n falling and the first SCLK edge.
- Internal latency from int_gnt to int_done = DIV + 2·DIV·FRAME_BITS + DIV cycles; with defaults this is 136.
- int_gnt and int_done are never asserted in the same cycle.
- A new grant is never issued in the cycle int_done pulses.

## Configuration
- SPI_ARB_WDOG_EN defined: counts clk cycles spent in MCU state. When the count reaches WDOG_CYCLES, the block forces per_cs_n = 8'hFF, sets err_collide, and waits for synced cs_n high before returning to IDLE.
- SPI_ARB_WDOG_EN undefined: no counter is built; MCU ownership is unbounded.

## Structure
- Package spi_arb_pkg holds the state enum, the FRAME_BITS default, and the 8'hFF all-deselected constant.
- Sub-module spi_shift_engine holds the DIV divider, bit counter and shift registers, with a start/busy/done interface. The arbiter FSM and output muxing live in spi_bus_arbiter.

## Test plan
- Internal write with int_sel = 1, int_wdata = 16'hA5C3 and a per_miso[1] loopback -> per_cs_n = 8'hFD for the frame, 16 SCLK pulses, int_rdata = 16'hA5C3, int_done exactly 136 cycles after int_gnt.
- MCU access with reg_mux = 8'h04, special_n high -> per_cs_n = 8'hFB within 3 cycles of the cs_n fall; MISO loopback matches; bus returns to IDLE after cs_n rises.
- int_req and MCU cs_n fall in the same cycle -> MCU is granted; int_gnt is issued only after the MCU's cs_n rises.
- MCU cs_n falls mid internal frame -> internal frame completes intact and err_collide = 1; clr_err drives it back to 0.
- special_n low with cs_n toggling -> per_cs_n stays 8'hFF throughout.
- rst_n pulsed low at bit 7 of an internal frame -> per_cs_n = 8'hFF and per_sclk = 0 immediately, no int_done; the next request completes normally.
